ser_shift_engine: RTL and testbench

Parametrised parallel-to-serial engine for the UART TX path, the successor of the fixed 8-bit serializer. It buffers one word behind the active word through a valid/ready handshake, supports a configurable width and a runtime LSB-/MSB-first order, and optionally appends a parity bit. The TX frame controller drives `ser_en` once per bit period. It muxes `ser_Data` onto the line between the start and stop bits.

---
 rtl/ser_pkg.sv | 39 +++
 rtl/ser_hold_reg.sv | 45 ++++
 rtl/ser_shift_engine.sv | 154 +++++++++++++++
 tb/tb_ser_shift_engine.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// +----------------------------------------------------------------------+
// | ser_pkg : shared types and helpers for the serial shift engine.      |
// | Rev 1.0 : initial release. PAR state present only with SER_PARITY_EN.|
// +----------------------------------------------------------------------+
`default_nettype none

package ser_pkg;

  localparam int c_max_w = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } ser_state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } ser_state_t;
`endif

  // Full-width reversal; callers shift the result down to their own width.
  function automatic logic [c_max_w-1:0] bit_rev32(input logic [c_max_w-1:0] v);
    logic [c_max_w-1:0] r;
    r = '0;
    for (int i = 0; i < c_max_w; i++) begin
      r[i] = v[c_max_w-1-i];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ser_hold_reg.sv
// +----------------------------------------------------------------------+
// | ser_hold_reg : one-entry valid/ready buffer ahead of the shifter.    |
// | Rev 1.0 : initial release.                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module ser_hold_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_clear,
  output logic              o_ready,
  output logic              o_full,
  output logic [DATA_W-1:0] o_data
);

  logic              r_full;
  logic [DATA_W-1:0] r_data;
  logic              w_accept;

  assign w_accept = i_valid && !r_full;

  // Clear only happens while full and accept only while empty, so they never collide.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (w_accept) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end
  end

  assign o_ready = !r_full;
  assign o_full  = r_full;
  assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/ser_shift_engine.sv
// +----------------------------------------------------------------------+
// | ser_shift_engine : parallel-to-serial engine for the UART TX path.   |
// | Optional parity bit enabled by defining SER_PARITY_EN.               |
// | Rev 1.0 : initial release.                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module ser_shift_engine
  import ser_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [DATA_W-1:0] P_DATA,
  input  logic              Data_Valid,
  output logic              data_ready,
  input  logic              ser_en,
  input  logic              msb_first,
`ifdef SER_PARITY_EN
  input  logic              par_typ,
`endif
  output logic              ser_Data,
  output logic              ser_done,
  output logic              underrun
);

  localparam int c_cnt_w = $clog2(DATA_W + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_W);

  ser_state_t        r_state, w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_ser_data, w_ser_data_nxt;
  logic              r_ser_done, w_ser_done_nxt;
  logic              r_underrun, w_underrun_nxt;
  logic              w_load;
  logic              w_hold_full;
  logic [DATA_W-1:0] w_hold_data;
  logic [DATA_W-1:0] w_rev;
  logic [DATA_W-1:0] w_word;
`ifdef SER_PARITY_EN
  logic              r_par, w_par_nxt;
`endif

  ser_hold_reg #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk     (clk),
    .RST     (RST),
    .i_valid (Data_Valid),
    .i_data  (P_DATA),
    .i_clear (w_load),
    .o_ready (data_ready),
    .o_full  (w_hold_full),
    .o_data  (w_hold_data)
  );

  // Reversed word lands in the top DATA_W bits of the 32-bit result.
  assign w_rev     = DATA_W'(bit_rev32(c_max_w'(w_hold_data)) >> (c_max_w - DATA_W));
  assign w_word    = msb_first ? w_rev : w_hold_data;
  assign w_cnt_inc = r_cnt + c_cnt_one;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_ser_data_nxt = r_ser_data;
    w_ser_done_nxt = 1'b0;
    w_underrun_nxt = 1'b0;
    w_load         = 1'b0;
`ifdef SER_PARITY_EN
    w_par_nxt      = r_par;
`endif
    case (r_state)
      IDLE: begin
        w_ser_data_nxt = 1'b1;
        if (ser_en) begin
          if (w_hold_full) begin
            w_load         = 1'b1;
            w_ser_data_nxt = w_word[0];
            w_shift_nxt    = w_word >> 1;
            w_cnt_nxt      = c_cnt_one;
            w_state_nxt    = SHIFT;
`ifdef SER_PARITY_EN
            w_par_nxt      = (par_typ == PAR_ODD) ? ~(^w_hold_data) : (^w_hold_data);
`endif
          end else begin
            w_underrun_nxt = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (ser_en) begin
          w_ser_data_nxt = r_shift[0];
          w_shift_nxt    = r_shift >> 1;
          w_cnt_nxt      = w_cnt_inc;
          if (w_cnt_inc == c_cnt_last) begin
`ifdef SER_PARITY_EN
            w_state_nxt    = PAR;
`else
            w_ser_done_nxt = 1'b1;
            w_state_nxt    = IDLE;
`endif
          end
        end
      end
`ifdef SER_PARITY_EN
      PAR: begin
        if (ser_en) begin
          w_ser_data_nxt = r_par;
          w_ser_done_nxt = 1'b1;
          w_state_nxt    = IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_ser_data <= 1'b1;
      r_ser_done <= 1'b0;
      r_underrun <= 1'b0;
`ifdef SER_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_ser_data <= w_ser_data_nxt;
      r_ser_done <= w_ser_done_nxt;
      r_underrun <= w_underrun_nxt;
`ifdef SER_PARITY_EN
      r_par      <= w_par_nxt;
`endif
    end
  end

  assign ser_Data = r_ser_data;
  assign ser_done = r_ser_done;
  assign underrun = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_ser_shift_engine.sv
// +----------------------------------------------------------------------+
// | tb_ser_shift_engine : directed self-checking bench, DATA_W = 8.      |
// | Rev 1.0 : initial release. Parity checks active with SER_PARITY_EN.  |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_ser_shift_engine;

`ifdef SER_PARITY_EN
  localparam bit c_par = 1'b1;
`else
  localparam bit c_par = 1'b0;
`endif

  logic       clk;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       data_ready;
  logic       ser_en;
  logic       msb_first;
`ifdef SER_PARITY_EN
  logic       par_typ;
`endif
  logic       ser_Data;
  logic       ser_done;
  logic       underrun;

  int n_checks = 0;
  int n_fail   = 0;

  ser_shift_engine #(
    .DATA_W (8)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .data_ready (data_ready),
    .ser_en     (ser_en),
    .msb_first  (msb_first),
`ifdef SER_PARITY_EN
    .par_typ    (par_typ),
`endif
    .ser_Data   (ser_Data),
    .ser_done   (ser_done),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // seq[i] is the i-th bit expected on the line; ser_en must already be high.
  task automatic run_bits(input string tag, input logic [7:0] seq);
    for (int i = 0; i < 8; i++) begin
      tick();
      check({tag, "_bit"}, 32'(ser_Data), 32'(seq[i]));
      check({tag, "_done"}, 32'(ser_done), 32'((i == 7) && !c_par));
      if (i == 0) check({tag, "_ready_after_load"}, 32'(data_ready), 32'(1));
    end
  endtask

`ifdef SER_PARITY_EN
  task automatic check_par(input string tag, input logic exp);
    tick();
    check({tag, "_par_bit"}, 32'(ser_Data), 32'(exp));
    check({tag, "_par_done"}, 32'(ser_done), 32'(1));
  endtask
`endif

  initial begin
    RST        = 1'b0;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    ser_en     = 1'b0;
    msb_first  = 1'b0;
`ifdef SER_PARITY_EN
    par_typ    = 1'b0;
`endif
    #12;
    check("rst_ser_data", 32'(ser_Data), 32'(1));
    check("rst_ready", 32'(data_ready), 32'(1));
    check("rst_done", 32'(ser_done), 32'(0));
    check("rst_underrun", 32'(underrun), 32'(0));
    RST = 1'b1;
    tick();

    // Underrun on every enabled idle cycle with nothing held
    ser_en = 1'b1;
    tick();
    check("udr1_pulse", 32'(underrun), 32'(1));
    check("udr1_line", 32'(ser_Data), 32'(1));
    tick();
    check("udr2_pulse", 32'(underrun), 32'(1));
    ser_en = 1'b0;
    tick();
    check("udr_clear", 32'(underrun), 32'(0));

    // LSB-first 0xC1
    P_DATA = 8'hC1; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    check("lsb_ready_low", 32'(data_ready), 32'(0));
    check("lsb_idle_line", 32'(ser_Data), 32'(1));
    ser_en = 1'b1;
    run_bits("lsb", 8'b1100_0001);
`ifdef SER_PARITY_EN
    check_par("lsb_even", 1'b1);
`endif
    ser_en = 1'b0;
    tick();
    check("lsb_back_idle", 32'(ser_Data), 32'(1));
    check("lsb_done_clear", 32'(ser_done), 32'(0));

    // MSB-first 0xC1 -> 1,1,0,0,0,0,0,1
    P_DATA = 8'hC1; Data_Valid = 1'b1; msb_first = 1'b1;
`ifdef SER_PARITY_EN
    par_typ = 1'b1;
`endif
    tick();
    Data_Valid = 1'b0;
    ser_en = 1'b1;
    run_bits("msb", 8'b1000_0011);
`ifdef SER_PARITY_EN
    check_par("msb_odd", 1'b0);
    par_typ = 1'b0;
`endif
    msb_first = 1'b0;
    ser_en = 1'b0;
    tick();

    // Stall after third bit of 0x3C (0,0,1,1,1,1,0,0), queue 0x5A meanwhile
    P_DATA = 8'h3C; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    ser_en = 1'b1;
    tick(); check("stl_b0", 32'(ser_Data), 32'(0));
    tick(); check("stl_b1", 32'(ser_Data), 32'(0));
    tick(); check("stl_b2", 32'(ser_Data), 32'(1));
    ser_en = 1'b0;
    P_DATA = 8'h5A; Data_Valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      Data_Valid = 1'b0;
      check("stl_hold_line", 32'(ser_Data), 32'(1));
      check("stl_hold_done", 32'(ser_done), 32'(0));
      check("stl_ready_low", 32'(data_ready), 32'(0));
    end
    ser_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic [4:0] rem;
      rem = 5'b00111;
      tick();
      check("stl_rest_bit", 32'(ser_Data), 32'(rem[i]));
      check("stl_rest_done", 32'(ser_done), 32'((i == 4) && !c_par));
      check("stl_rest_ready", 32'(data_ready), 32'(0));
    end
`ifdef SER_PARITY_EN
    check_par("stl_even", 1'b0);
`endif
    // Queued 0x5A follows after the single idle edge
    run_bits("b2b", 8'h5A);
`ifdef SER_PARITY_EN
    check_par("b2b_even", 1'b0);
`endif
    ser_en = 1'b0;
    tick();

    // Reset mid-word with a second word queued
    P_DATA = 8'hF0; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    ser_en = 1'b1;
    tick();
    P_DATA = 8'h0F; Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
    tick();
    check("mid_bit2", 32'(ser_Data), 32'(0));
    check("mid_ready_low", 32'(data_ready), 32'(0));
    #2;
    RST = 1'b0;
    #1;
    check("mid_rst_line", 32'(ser_Data), 32'(1));
    check("mid_rst_ready", 32'(data_ready), 32'(1));
    check("mid_rst_done", 32'(ser_done), 32'(0));
    check("mid_rst_underrun", 32'(underrun), 32'(0));
    RST = 1'b1;
    tick();
    check("post_rst_underrun", 32'(underrun), 32'(1));
    check("post_rst_line", 32'(ser_Data), 32'(1));
    ser_en = 1'b0;
    tick();
    check("post_rst_quiet", 32'(underrun), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
